// File: rtl/prog_rate_pulse_gen_if.sv
// Control/status bundle for prog_rate_pulse_gen.
// The master side drives the run controls and divisor loads.
// The slave side (the generator) returns the strobes and busy flag.
interface prog_rate_pulse_gen_if #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned BURST_W = 8
);
    logic               en;
    logic               mode;
    logic               start;
    logic [BURST_W-1:0] burst_len;
    logic               div_load;
    logic [CNT_W-1:0]   div_val;
    logic               pulse;
    logic               busy;
    logic               done;
    logic               div_err;

    modport master (
        output en,
        output mode,
        output start,
        output burst_len,
        output div_load,
        output div_val,
        input  pulse,
        input  busy,
        input  done,
        input  div_err
    );

    modport slave (
        input  en,
        input  mode,
        input  start,
        input  burst_len,
        input  div_load,
        input  div_val,
        output pulse,
        output busy,
        output done,
        output div_err
    );
endinterface

// File: rtl/prog_rate_pulse_gen.sv
// Programmable-rate pulse generator.
// Divides clk by a runtime-loadable divisor and emits 1-cycle strobes, either
// continuously or as a counted burst. Divisor changes made while running are
// held as pending and only take effect on a period boundary, so the period in
// flight is never truncated or stretched.
module prog_rate_pulse_gen #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 10000,
    parameter int unsigned BURST_W     = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    prog_rate_pulse_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle,
        StRunCont,
        StRunBurst
    } state_e;

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_active_div;
    logic [CNT_W-1:0]   r_pend_div;
    logic               r_pend_vld;
    logic [BURST_W-1:0] r_remaining;
    logic               r_pulse;
    logic               r_busy;
    logic               r_done;
    logic               r_div_err;

    logic               w_div_ok;
    logic               w_div_bad;
    logic               w_wrap;
    logic               w_start_cont;
    logic               w_start_burst;
    logic               w_last_pulse;
    logic [CNT_W-1:0]   w_next_div;

    // Decode load validity, period wrap and IDLE exit conditions.
    always_comb begin
        w_div_ok      = bus.div_load && (bus.div_val >= CNT_W'(2));
        w_div_bad     = bus.div_load && (bus.div_val <  CNT_W'(2));
        w_wrap        = (r_cnt == (r_active_div - CNT_W'(1)));
        w_start_cont  = bus.en && !bus.mode;
        w_start_burst = bus.en && bus.mode && bus.start && (bus.burst_len != '0);
        w_last_pulse  = (r_remaining == BURST_W'(1));
        // A load accepted on the boundary edge beats anything already pending.
        if (w_div_ok) begin
            w_next_div = bus.div_val;
        end else if (r_pend_vld) begin
            w_next_div = r_pend_div;
        end else begin
            w_next_div = r_active_div;
        end
    end

    // Control FSM, period counter, divisor bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_active_div <= CNT_W'(DEFAULT_DIV);
            r_pend_div   <= '0;
            r_pend_vld   <= 1'b0;
            r_remaining  <= '0;
            r_pulse      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_div_err    <= 1'b0;
        end else begin
            r_pulse   <= 1'b0;
            r_done    <= 1'b0;
            r_div_err <= w_div_bad;

            unique case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (w_div_ok) begin
                        r_active_div <= bus.div_val;
                    end
                    if (w_start_cont) begin
                        r_state <= StRunCont;
                        r_busy  <= 1'b1;
                    end else if (w_start_burst) begin
                        r_state     <= StRunBurst;
                        r_busy      <= 1'b1;
                        r_remaining <= bus.burst_len;
                    end
                end

                StRunCont, StRunBurst: begin
                    if (!bus.en) begin
                        // Abort: no strobe this edge, but a pending divisor is not lost.
                        r_state      <= StIdle;
                        r_busy       <= 1'b0;
                        r_cnt        <= '0;
                        r_remaining  <= '0;
                        r_active_div <= w_next_div;
                        r_pend_vld   <= 1'b0;
                    end else if (w_wrap) begin
                        r_cnt        <= '0;
                        r_pulse      <= 1'b1;
                        r_active_div <= w_next_div;
                        r_pend_vld   <= 1'b0;
                        if (r_state == StRunBurst) begin
                            r_remaining <= r_remaining - BURST_W'(1);
                            if (w_last_pulse) begin
                                r_done  <= 1'b1;
                                r_state <= StIdle;
                                r_busy  <= 1'b0;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_div_ok) begin
                            r_pend_div <= bus.div_val;
                            r_pend_vld <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.pulse   = r_pulse;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.div_err = r_div_err;

endmodule

// File: tb/tb_prog_rate_pulse_gen.sv
// Self-checking bench for prog_rate_pulse_gen.
// Expected pulse cycles (with their done flag) are queued when a run is started
// and popped whenever the generator strobes.
module tb_prog_rate_pulse_gen;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned BURST_W = 8;
    localparam int unsigned DEF_DIV = 10000;

    typedef struct {
        int unsigned cyc;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst;
    int unsigned cyc = 0;
    int unsigned n_total = 0;
    int unsigned n_bad = 0;
    int unsigned e_cyc;
    exp_t        exp_q[$];

    prog_rate_pulse_gen_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

    prog_rate_pulse_gen #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV),
        .BURST_W     (BURST_W)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Edge counter used as the time base for expected pulses.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input int unsigned c, input logic d);
        exp_t e;
        e.cyc  = c;
        e.done = d;
        exp_q.push_back(e);
    endtask

    // Advance to the next falling edge and score whatever the DUT produced.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (bus.pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("pulse_spurious", bus.pulse, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("pulse_cyc", cyc, e.cyc);
                check_eq("done_with_pulse", bus.done, e.done);
            end
        end else if (bus.done === 1'b1) begin
            check_eq("done_without_pulse", bus.done, 0);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check_eq("pulse_missing", cyc, e.cyc);
        end
    endtask

    task automatic load_idle(input int unsigned d);
        bus.div_load = 1'b1;
        bus.div_val  = CNT_W'(d);
        tick();
        bus.div_load = 1'b0;
    endtask

    task automatic stop_and_drain(input string tag);
        bus.en    = 1'b0;
        bus.start = 1'b0;
        repeat (4) tick();
        check_eq(tag, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nrst          = 1'b0;
        bus.en        = 1'b0;
        bus.mode      = 1'b0;
        bus.start     = 1'b0;
        bus.burst_len = '0;
        bus.div_load  = 1'b0;
        bus.div_val   = '0;
        repeat (3) tick();
        check_eq("rst_pulse", bus.pulse, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_div_err", bus.div_err, 0);
        nrst = 1'b1;
        tick();

        // Continuous mode, DIV=4: pulses at entry+4, +8, +12.
        load_idle(4);
        bus.en   = 1'b1;
        bus.mode = 1'b0;
        e_cyc    = cyc + 1;
        for (int i = 1; i <= 3; i++) push_exp(e_cyc + 4 * i, 1'b0);
        tick();
        check_eq("cont_busy", bus.busy, 1);
        while (cyc < e_cyc + 12) tick();
        bus.en = 1'b0;
        tick();
        check_eq("cont_abort_busy", bus.busy, 0);
        stop_and_drain("cont_q_empty");

        // Burst DIV=5 len 3; a start mid-burst must be ignored.
        load_idle(5);
        bus.en        = 1'b1;
        bus.mode      = 1'b1;
        bus.start     = 1'b1;
        bus.burst_len = 8'd3;
        e_cyc         = cyc + 1;
        push_exp(e_cyc + 5, 1'b0);
        push_exp(e_cyc + 10, 1'b0);
        push_exp(e_cyc + 15, 1'b1);
        tick();
        bus.start = 1'b0;
        check_eq("burst_busy", bus.busy, 1);
        while (cyc < e_cyc + 15) begin
            bus.start     = (cyc == e_cyc + 7);
            bus.burst_len = (cyc == e_cyc + 7) ? 8'd7 : 8'd3;
            tick();
        end
        bus.start = 1'b0;
        check_eq("burst_end_busy", bus.busy, 0);
        repeat (3) tick();
        bus.start     = 1'b1;
        bus.burst_len = '0;
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        check_eq("burst_len0_busy", bus.busy, 0);
        stop_and_drain("burst_q_empty");

        // DIV=10, loads 6 then 4 mid-period; load 3 on a wrap edge.
        bus.mode = 1'b0;
        load_idle(10);
        bus.en = 1'b1;
        e_cyc  = cyc + 1;
        push_exp(e_cyc + 10, 1'b0);
        push_exp(e_cyc + 14, 1'b0);
        push_exp(e_cyc + 18, 1'b0);
        push_exp(e_cyc + 21, 1'b0);
        push_exp(e_cyc + 24, 1'b0);
        tick();
        for (int k = 1; k <= 25; k++) begin
            bus.div_load = (k == 3) || (k == 7) || (k == 18);
            bus.div_val  = (k == 3) ? 16'd6 : (k == 7) ? 16'd4 : 16'd3;
            tick();
        end
        bus.div_load = 1'b0;
        stop_and_drain("reload_q_empty");

        // Rejected loads of 1 and 0 while running DIV=6.
        load_idle(6);
        bus.en = 1'b1;
        e_cyc  = cyc + 1;
        for (int i = 1; i <= 3; i++) push_exp(e_cyc + 6 * i, 1'b0);
        tick();
        for (int k = 1; k <= 18; k++) begin
            bus.div_load = (k == 2) || (k == 4);
            bus.div_val  = (k == 2) ? 16'd1 : 16'd0;
            tick();
            if (k >= 2 && k <= 5) check_eq("div_err", bus.div_err, (k == 2 || k == 4) ? 1 : 0);
        end
        bus.div_load = 1'b0;
        stop_and_drain("diverr_q_empty");

        // Burst aborted on the wrap edge of its second pulse.
        load_idle(5);
        bus.en        = 1'b1;
        bus.mode      = 1'b1;
        bus.start     = 1'b1;
        bus.burst_len = 8'd3;
        e_cyc         = cyc + 1;
        push_exp(e_cyc + 5, 1'b0);
        tick();
        bus.start = 1'b0;
        while (cyc < e_cyc + 9) tick();
        bus.en = 1'b0;
        tick();
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_pulse", bus.pulse, 0);
        check_eq("abort_done", bus.done, 0);
        repeat (10) tick();
        check_eq("abort_idle_busy", bus.busy, 0);
        stop_and_drain("abort_q_empty");

        // Async reset while running: outputs clear at once, divisor back to default.
        bus.mode = 1'b0;
        load_idle(4);
        bus.en = 1'b1;
        e_cyc  = cyc + 1;
        push_exp(e_cyc + 4, 1'b0);
        tick();
        while (cyc < e_cyc + 4) tick();
        #2;
        exp_q.delete();
        nrst = 1'b0;
        #1;
        check_eq("async_rst_pulse", bus.pulse, 0);
        check_eq("async_rst_busy", bus.busy, 0);
        check_eq("async_rst_done", bus.done, 0);
        bus.en = 1'b0;
        tick();
        tick();
        nrst   = 1'b1;
        bus.en = 1'b1;
        e_cyc  = cyc + 1;
        push_exp(e_cyc + DEF_DIV, 1'b0);
        tick();
        while (cyc < e_cyc + DEF_DIV + 1) tick();
        stop_and_drain("default_div_q_empty");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
